// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
package mux2_rr_arbiter_pkg;

  localparam int CountW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

endpackage

// File: rtl/mux2_rr_arbiter_mux2_nbits.sv
// nbits-wide 2:1 mux carrying the granted requester's message.
module mux2_nbits #(
  parameter int nbits = 8
) (
  input  logic             sel_i,
  input  logic [nbits-1:0] in0_i,
  input  logic [nbits-1:0] in1_i,
  output logic [nbits-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one val/rdy channel between two requesters,
// with a bounded grant-hold count for fairness.
module mux2_rr_arbiter #(
  parameter int nbits    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in0_val_i,
  output logic             in0_rdy_o,
  input  logic [nbits-1:0] in0_msg_i,
  input  logic             in1_val_i,
  output logic             in1_rdy_o,
  input  logic [nbits-1:0] in1_msg_i,
  output logic             out_val_o,
  input  logic             out_rdy_i,
  output logic [nbits-1:0] out_msg_o,
  output logic             sel_o
);

  import mux2_rr_arbiter_pkg::*;

  localparam logic [CountW:0] HoldLim = (CountW+1)'(MAX_HOLD);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CountW-1:0] count_q, count_d;
  logic [CountW:0]   countInc;
  logic              xfer;
  logic              holdDone;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign xfer     = out_val_o & out_rdy_i;
  assign countInc = {1'b0, count_q} + {{CountW{1'b0}}, 1'b1};
  assign holdDone = countInc >= HoldLim;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (in0_val_i && in1_val_i) state_d = last_q ? G0 : G1;
        else if (in0_val_i)         state_d = G0;
        else if (in1_val_i)         state_d = G1;
      end
      G0: begin
        if (!in0_val_i)                        state_d = in1_val_i ? G1 : IDLE;
        else if (xfer && holdDone && in1_val_i) state_d = G1;
        else if (xfer && ({1'b0, count_q} < HoldLim)) count_d = countInc[CountW-1:0];
      end
      G1: begin
        if (!in1_val_i)                        state_d = in0_val_i ? G0 : IDLE;
        else if (xfer && holdDone && in0_val_i) state_d = G0;
        else if (xfer && ({1'b0, count_q} < HoldLim)) count_d = countInc[CountW-1:0];
      end
      default: state_d = IDLE;
    endcase
    // A fresh grant restarts the hold count and becomes the tie-break reference.
    if ((state_d != state_q) && (state_d != IDLE)) begin
      count_d = '0;
      last_d  = (state_d == G1);
    end
  end

  always_comb begin
    sel_o     = (state_q == G1);
    out_val_o = 1'b0;
    in0_rdy_o = 1'b0;
    in1_rdy_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        G0: begin
          out_val_o = in0_val_i;
          in0_rdy_o = out_rdy_i;
        end
        G1: begin
          out_val_o = in1_val_i;
          in1_rdy_o = out_rdy_i;
        end
        default: ;
      endcase
    end
  end

  mux2_nbits #(.nbits(nbits)) msgMux (
    .sel_i (sel_o),
    .in0_i (in0_msg_i),
    .in1_i (in1_msg_i),
    .out_o (out_msg_o)
  );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed vector table, hand sequences and a
// randomized run against a grant/fairness reference model.
module tb_mux2_rr_arbiter;

  localparam int NBITS   = 8;
  localparam int MAXHOLD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in0Val, in1Val, outRdy;
  logic [NBITS-1:0] in0Msg, in1Msg;
  logic             in0Rdy, in1Rdy, outVal, sel;
  logic [NBITS-1:0] outMsg;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: -1 = no grant, else index of the granted requester.
  int mGrant = -1;
  int mLast  = 1;
  int mCount = 0;

  typedef struct {
    logic       r;
    logic       v0;
    logic [7:0] m0;
    logic       v1;
    logic [7:0] m1;
    logic       ordy;
    logic       eVal;
    logic       eRdy0;
    logic       eRdy1;
    logic       eSel;
    logic [7:0] eMsg;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.nbits(NBITS), .MAX_HOLD(MAXHOLD)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .in0_val_i (in0Val),
    .in0_rdy_o (in0Rdy),
    .in0_msg_i (in0Msg),
    .in1_val_i (in1Val),
    .in1_rdy_o (in1Rdy),
    .in1_msg_i (in1Msg),
    .out_val_o (outVal),
    .out_rdy_i (outRdy),
    .out_msg_o (outMsg),
    .sel_o     (sel)
  );

  task automatic cmp(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v0, input logic [7:0] m0,
                               input logic v1, input logic [7:0] m1, input logic ordy);
    rst    = r;
    in0Val = v0;
    in0Msg = m0;
    in1Val = v1;
    in1Msg = m1;
    outRdy = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic eVal, input logic eRdy0,
                             input logic eRdy1, input logic eSel, input logic [7:0] eMsg);
    cmp({tag, ".out_val"}, int'(outVal), int'(eVal));
    cmp({tag, ".in0_rdy"}, int'(in0Rdy), int'(eRdy0));
    cmp({tag, ".in1_rdy"}, int'(in1Rdy), int'(eRdy1));
    cmp({tag, ".sel"},     int'(sel),    int'(eSel));
    cmp({tag, ".out_msg"}, int'(outMsg), int'(eMsg));
  endtask

  // Advance the model by the arbitration rules using the inputs of this cycle.
  task automatic modelStep();
    int  ng;
    bit  vk, vj, x;
    if (rst) begin
      mGrant = -1;
      mLast  = 1;
      mCount = 0;
    end else begin
      if (mGrant < 0) begin
        if (in0Val && in1Val) ng = 1 - mLast;
        else if (in0Val)      ng = 0;
        else if (in1Val)      ng = 1;
        else                  ng = -1;
      end else begin
        vk = (mGrant == 0) ? in0Val : in1Val;
        vj = (mGrant == 0) ? in1Val : in0Val;
        x  = vk && outRdy;
        if (!vk)                                   ng = vj ? 1 - mGrant : -1;
        else if (x && mCount + 1 >= MAXHOLD && vj) ng = 1 - mGrant;
        else begin
          ng = mGrant;
          if (x && mCount < MAXHOLD) mCount++;
        end
      end
      if (ng >= 0 && ng != mGrant) begin
        mCount = 0;
        mLast  = ng;
      end
      mGrant = ng;
    end
  endtask

  task automatic stepEdge();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic v0, input logic [7:0] m0,
                              input logic v1, input logic [7:0] m1, input logic ordy,
                              input logic eVal, input logic eRdy0, input logic eRdy1,
                              input logic eSel, input logic [7:0] eMsg);
    vec_t v;
    v.r = r; v.v0 = v0; v.m0 = m0; v.v1 = v1; v.m1 = m1; v.ordy = ordy;
    v.eVal = eVal; v.eRdy0 = eRdy0; v.eRdy1 = eRdy1; v.eSel = eSel; v.eMsg = eMsg;
    return v;
  endfunction

  initial begin
    logic [6:0] seq0, seq1;
    logic       r, v0, v1, ordy, eSel, eVal;

    vecs[0]  = mk(1, 1, 8'hA5, 0, 8'h00, 1,  0, 0, 0, 0, 8'hA5);
    vecs[1]  = mk(0, 1, 8'hA5, 0, 8'h00, 1,  0, 0, 0, 0, 8'hA5);
    vecs[2]  = mk(0, 1, 8'hA5, 0, 8'h00, 1,  1, 1, 0, 0, 8'hA5);
    vecs[3]  = mk(0, 1, 8'h00, 1, 8'h11, 1,  1, 1, 0, 0, 8'h00);
    vecs[4]  = mk(0, 1, 8'h00, 1, 8'h11, 1,  1, 1, 0, 0, 8'h00);
    vecs[5]  = mk(0, 1, 8'h00, 1, 8'h11, 1,  1, 1, 0, 0, 8'h00);
    vecs[6]  = mk(0, 1, 8'h00, 1, 8'h11, 1,  1, 0, 1, 1, 8'h11);
    vecs[7]  = mk(0, 1, 8'h00, 1, 8'h11, 0,  1, 0, 0, 1, 8'h11);
    vecs[8]  = mk(0, 1, 8'h00, 1, 8'h11, 0,  1, 0, 0, 1, 8'h11);
    vecs[9]  = mk(0, 1, 8'h00, 1, 8'h11, 1,  1, 0, 1, 1, 8'h11);
    vecs[10] = mk(1, 1, 8'h00, 1, 8'h11, 1,  0, 0, 0, 1, 8'h11);
    vecs[11] = mk(0, 1, 8'h00, 1, 8'h11, 1,  0, 0, 0, 0, 8'h00);
    vecs[12] = mk(0, 1, 8'h00, 1, 8'h11, 1,  1, 1, 0, 0, 8'h00);
    vecs[13] = mk(0, 0, 8'h00, 1, 8'h11, 1,  0, 1, 0, 0, 8'h00);
    vecs[14] = mk(0, 1, 8'h00, 1, 8'h11, 1,  1, 0, 1, 1, 8'h11);

    applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
    @(posedge clk);
    #1;
    stepEdge();

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].r, vecs[i].v0, vecs[i].m0, vecs[i].v1, vecs[i].m1, vecs[i].ordy);
      #4;
      checkOutput($sformatf("vec%0d", i), vecs[i].eVal, vecs[i].eRdy0, vecs[i].eRdy1,
                  vecs[i].eSel, vecs[i].eMsg);
      stepEdge();
    end

    // Full load: MAX_HOLD from each requester in turn with no bubbles.
    applyStimulus(1, 1, 8'h00, 1, 8'h11, 1);
    stepEdge();
    applyStimulus(0, 1, 8'h00, 1, 8'h11, 1);
    #4;
    checkOutput("fair.arb", 0, 0, 0, 0, 8'h00);
    stepEdge();
    for (int i = 0; i < 3 * MAXHOLD; i++) begin
      eSel = ((i / MAXHOLD) % 2) == 1;
      #4;
      checkOutput($sformatf("fair%0d", i), 1, !eSel, eSel, eSel, eSel ? 8'h11 : 8'h00);
      stepEdge();
    end

    // A lone requester keeps its grant past the hold limit.
    applyStimulus(1, 0, 8'h22, 1, 8'h33, 1);
    stepEdge();
    applyStimulus(0, 0, 8'h22, 1, 8'h33, 1);
    #4;
    checkOutput("lone.arb", 0, 0, 0, 0, 8'h22);
    stepEdge();
    for (int i = 0; i < 10; i++) begin
      #4;
      checkOutput($sformatf("lone%0d", i), 1, 0, 1, 1, 8'h33);
      stepEdge();
    end

    // Random traffic; each producer holds its message until it is accepted.
    seq0 = '0;
    seq1 = '0;
    for (int i = 0; i < 500; i++) begin
      r    = ($urandom_range(0, 59) == 0);
      v0   = ($urandom_range(0, 3) != 0);
      v1   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 4) != 0);
      applyStimulus(r, v0, {1'b0, seq0}, v1, {1'b1, seq1}, ordy);
      #4;
      eSel = (mGrant == 1);
      eVal = !r && ((mGrant == 0 && v0) || (mGrant == 1 && v1));
      checkOutput($sformatf("rnd%0d", i), eVal, !r && mGrant == 0 && ordy,
                  !r && mGrant == 1 && ordy, eSel,
                  eSel ? {1'b1, seq1} : {1'b0, seq0});
      if (in0Val && in0Rdy) seq0 = seq0 + 7'd1;
      if (in1Val && in1Rdy) seq1 = seq1 + 7'd1;
      stepEdge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
